// File: rtl/instruction_fetch_queue_if.sv
// rtl/instruction_fetch_queue_if.sv - instruction memory read bus between fetch and memory
interface instruction_fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - fetch request FSM with PC/instruction FIFO feeding decode
module instruction_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [31:0]               pc_address,
  output logic                      pc_pause,
  input  logic                      flush,
  instruction_fetch_queue_if.master mem,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instruction,
  output logic [31:0]               out_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // WAIT keeps the returning word, DRAIN throws away a wrong-path word
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state;
  state_t        state_next;
  logic [AW:0]   count;
  logic [AW:0]   slots;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   fifo_instruction [DEPTH];
  logic [31:0]   fifo_pc          [DEPTH];
  logic          accept;
  logic          push;
  logic          pop;

  // An outstanding kept request reserves its slot; a same-cycle pop is not counted as free room
  assign slots     = count + {{AW{1'b0}}, state == WAIT};
  assign accept    = !flush && (slots < FULL) && ((state == IDLE) || ((state == WAIT) && mem.mem_ack));
  assign push      = (state == WAIT) && mem.mem_ack && !flush;
  assign pop       = out_valid && out_ready && !flush;
  // Pause is forced low on flush so the PC override always wins
  assign pc_pause  = !accept && !flush;
  assign out_valid = (count != '0);
  assign out_instruction = fifo_instruction[rd_ptr];
  assign out_pc          = fifo_pc[rd_ptr];

  // Next request state from accept, ack and flush
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WAIT;
      WAIT: begin
        if (mem.mem_ack)  state_next = accept ? WAIT : IDLE;
        else if (flush)   state_next = DRAIN;
      end
      DRAIN:   if (mem.mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and registered memory request; address only moves on accept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      state       <= state_next;
      mem.mem_req <= (state_next != IDLE);
      if (accept) mem.mem_addr <= pc_address;
    end
  end

  // FIFO occupancy and pointers; flush empties the queue and overrides push/pop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
    end
  end

  // FIFO storage: returned word tagged with the address it was fetched from
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instruction[wr_ptr] <= mem.mem_rdata;
      fifo_pc[wr_ptr]          <= mem.mem_addr;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - randomized model-based bench for instruction_fetch_queue
module tb_instruction_fetch_queue;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] pc_address;
  logic        pc_pause;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  instruction_fetch_queue_if mem ();

  instruction_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pc_address      (pc_address),
    .pc_pause        (pc_pause),
    .flush           (flush),
    .mem             (mem),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of fetched entries plus one outstanding request
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];
  bit          has_req;
  bit          live;
  logic [31:0] req_addr;
  logic [31:0] pc;
  int          lat;
  int          age;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_dut(input logic [31:0] pc0);
    reset_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    mem.mem_ack = 1'b0;
    mem.mem_rdata = '0;
    pc = pc0;
    pc_address = pc0;
    #1;
    chk("reset mem_req", mem.mem_req, 0);
    chk("reset mem_addr", mem.mem_addr, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset pc_pause", pc_pause, 0);
    q_pc.delete();
    q_in.delete();
    has_req = 0;
    live = 0;
    req_addr = '0;
    age = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model and PC
  task automatic step(input bit fl, input logic [31:0] tgt, input bit rdy);
    bit ack_v;
    bit exp_valid;
    bit room;
    bit issue;
    bit exp_pause;
    flush = fl;
    out_ready = rdy;
    pc_address = pc;
    if (lat < 0) ack_v = mem.mem_req && ($urandom_range(0, 2) == 0);
    else         ack_v = mem.mem_req && (age >= lat);
    mem.mem_ack = ack_v;
    mem.mem_rdata = ack_v ? mem_fn(mem.mem_addr) : $urandom();
    @(negedge clock);
    exp_valid = (q_pc.size() != 0);
    room = (q_pc.size() + ((has_req && live) ? 1 : 0)) < DEPTH;
    issue = !fl && room && (!has_req || (live && ack_v));
    exp_pause = !issue && !fl;
    chk("mem_req", mem.mem_req, has_req);
    chk("mem_addr", mem.mem_addr, req_addr);
    chk("out_valid", out_valid, exp_valid);
    chk("pc_pause", pc_pause, exp_pause);
    if (exp_valid) begin
      chk("out_pc", out_pc, q_pc[0]);
      chk("out_instruction", out_instruction, q_in[0]);
    end
    if (fl) begin
      q_pc.delete();
      q_in.delete();
      if (has_req) begin
        if (ack_v) has_req = 0;
        else       live = 0;
      end
    end else begin
      if (exp_valid && rdy) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (has_req && ack_v) begin
        if (live) begin
          q_pc.push_back(req_addr);
          q_in.push_back(mem_fn(req_addr));
        end
        has_req = 0;
      end
    end
    if (issue) begin
      has_req = 1;
      live = 1;
      req_addr = pc;
    end
    @(posedge clock);
    #1;
    if (ack_v)        age = 0;
    else if (has_req) age++;
    if (fl)              pc = tgt;
    else if (!exp_pause) pc = pc + 32'd4;
  endtask

  initial begin
    lat = 0;
    reset_dut(32'h0);

    // Streaming, zero-wait memory
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1);
      if (i == 0) begin
        chk("stream first mem_req", mem.mem_req, 1);
        chk("stream first mem_addr", mem.mem_addr, 0);
        chk("stream no early valid", out_valid, 0);
      end
      if (i == 1) begin
        chk("stream first valid", out_valid, 1);
        chk("stream first pc", out_pc, 0);
        chk("stream first instr", out_instruction, mem_fn(32'h0));
      end
      if (i == 4) chk("stream pc 12", out_pc, 32'd12);
    end

    // Backpressure fills exactly DEPTH entries
    reset_dut(32'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    chk("full pc_pause", pc_pause, 1);
    chk("full head pc", out_pc, 0);
    chk("full mem_req", mem.mem_req, 0);
    chk("full last addr", mem.mem_addr, 32'd12);
    chk("full pc_address held", pc_address, 32'd16);
    for (int i = 0; i < 14; i++) step(0, 0, 1);

    // Three-cycle wait states
    reset_dut(32'h0);
    lat = 3;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1);
      if (i == 2) begin
        chk("wait addr stable", mem.mem_addr, 0);
        chk("wait req held", mem.mem_req, 1);
      end
    end

    // Flush while a kept request is outstanding
    reset_dut(32'h18);
    lat = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("pre-flush queued head", out_pc, 32'h18);
    lat = 100;
    step(1, 32'h100, 1);
    chk("flush empties fifo", out_valid, 0);
    chk("drain mem_req", mem.mem_req, 1);
    chk("drain mem_addr", mem.mem_addr, 32'h20);
    lat = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("redirect valid", out_valid, 1);
    chk("redirect first pc", out_pc, 32'h100);
    for (int i = 0; i < 4; i++) step(0, 0, 1);

    // Flush with simultaneous ack and pop
    reset_dut(32'h0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 32'h200, 1);
    chk("flush-ack out_valid", out_valid, 0);
    chk("flush-ack idle", mem.mem_req, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1);

    // Reset in the middle of an outstanding request
    lat = 100;
    step(0, 0, 1);
    chk("mid-wait req up", mem.mem_req, 1);
    reset_dut(32'h400);
    lat = 0;
    step(0, 0, 1);
    chk("post-reset addr", mem.mem_addr, 32'h400);

    // Randomized traffic with random wait states, backpressure and redirects
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      bit fl;
      bit rdy;
      logic [31:0] tgt;
      fl = ($urandom_range(0, 15) == 0);
      tgt = $urandom() & 32'h0000_FFFC;
      if (((i / 200) % 2) == 0) rdy = ($urandom_range(0, 3) != 0);
      else                      rdy = ($urandom_range(0, 3) == 0);
      step(fl, tgt, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Fetch stage between the program counter and decode. Each cycle it takes the current PC, issues one word read to instruction memory over a req/ack handshake, and buffers returned instructions with their PC in a small FIFO for decode. It throttles the PC through `pc_pause` and discards wrong-path work on `flush`, which is driven by the same event as the PC override.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pc_address`  in  32  current PC (program counter `instruction_address`).
- `pc_pause`  out  1  combinational; to program counter `pause`.
- `flush`  in  1  redirect; asserted in the same cycle as the PC `override`.
- `mem_req`  out  1  read request, registered.
- `mem_addr`  out  32  read address, registered.
- `mem_ack`  in  1  response valid; meaningful only while `mem_req`=1.
- `mem_rdata`  in  32  instruction word, valid in the `mem_ack` cycle.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  decode accepts the head.
- `out_instruction`  out  32  head instruction.
- `out_pc`  out  32  head PC.

## Operation
- States: IDLE (no request outstanding), WAIT (request outstanding, data kept), DRAIN (request outstanding, data discarded).
- `mem_req` = 1 in WAIT and DRAIN. `mem_addr` changes only on accept.
- `slots` = `count` + (WAIT ? 1 : 0). A pop in the same cycle does not free a slot for accept.
- accept = !`flush` && `slots` < `DEPTH` && (IDLE || (WAIT && `mem_ack`)).
- On accept: `mem_addr` ← `pc_address`, and the next state is WAIT.
- `pc_pause` = !accept && !`flush`. It is forced low on `flush` so that the PC's pause priority cannot block the override.
- WAIT with `mem_ack`: push {`mem_addr`, `mem_rdata`}. The next state is WAIT on accept, otherwise IDLE.
- Memory protocol: `mem_req` held high with `mem_addr` stable until `mem_ack`. Each ack completes exactly one request. If `mem_req` stays high after an ack, that is a new request at the new `mem_addr`.
- Pop when `out_valid` && `out_ready` && !`flush`. Push and pop may occur in the same cycle, so `count` is unchanged.
- `out_valid` = (`count` ≠ 0). `out_instruction`/`out_pc` come from the head entry and are don't-care when `out_valid`=0.
- `flush`:
  - clears the FIFO (`count`←0, pointers←0) and overrides any push or pop that cycle;
  - IDLE → IDLE;
  - WAIT without `mem_ack` → DRAIN;
  - WAIT with `mem_ack` → IDLE, data dropped.
- DRAIN: `pc_pause`=1. On `mem_ack`, data is dropped and the next state is IDLE. `flush` in DRAIN keeps the block in DRAIN.
- No alignment checking on `pc_address`.

## Timing
- Reset (async assert, deasserted synchronously by the environment):
  - state IDLE, `count` 0, pointers 0;
  - `mem_req` 0, `mem_addr` 0;
  - `out_valid` 0, `pc_pause` 0.
- Latency: PC accepted in cycle N → `mem_req`/`mem_addr` in N+1. With ack in N+k (k≥1), `out_valid` with that entry in N+k+1.
- Zero-wait memory (ack every cycle the request is up) with `slots` < `DEPTH` sustains one instruction per cycle. The PC advances every cycle.
- With FIFO full and no pop, `pc_pause` stays high and `pc_address` is held.
- Redirect: `flush` in cycle F → target accepted in F+1 from IDLE, or one cycle after the drain ack. No wrong-path entry ever reaches `out_valid`.
- `reset_n` low mid-transaction: an outstanding request is abandoned (`mem_req` drops immediately). The memory must tolerate this.

## Test plan
- Reset: `reset_n`=0 with `mem_req` high mid-WAIT → `mem_req`=0, `out_valid`=0, `pc_pause`=0 immediately. After release, the first accepted address is whatever `pc_address` shows.
- Streaming: zero-wait memory, `out_ready`=1, PC from 0 → `out_pc` 0,4,8,12… one per cycle, with `out_instruction` = memory[addr]. First `out_valid` 2 cycles after the first accept.
- Backpressure: `out_ready`=0, DEPTH=4 → exactly 4 entries (PCs 0..12). `pc_pause`=1 holding PC at 16. Raise `out_ready` → entries drain in order, then fetch resumes at 16 with no gap or duplicate.
- Wait states: ack 3 cycles after each request → `mem_addr` stable for those cycles and `pc_pause` high throughout. Outputs are 0,4,8 in order.
- Flush in WAIT: request for 0x20 outstanding, 2 entries queued, `flush` with target 0x100 → FIFO empty next cycle and DRAIN until ack. The 0x20 data is dropped. Next request is 0x100, and the first `out_pc`=0x100.
- Flush with simultaneous ack and `out_valid`&&`out_ready` → no pop is counted, ack data dropped, next state IDLE. `pc_pause`=0 in the flush cycle.
